// File: rtl/lcd_controller.sv
// ---------------------------------------------------------------------------
// lcd_controller
//
// Drives the 4-bit character-LCD transfer unit (sendCommand/commandDone
// nibble engine). After reset it waits out the LCD power-up time, plays the
// fixed HD44780 4-bit initialisation ROM, and then accepts byte writes from
// the client. Each byte becomes two nibble transfers (high, then low). Each
// transfer carries the post-nibble delay that the transfer unit waits after
// strobing the nibble.
//
// Parameters
//   FREQ            clock frequency in Hz (T_US = FREQ/1e6 cycles per us)
//   POWERUP_CYCLES  power-up wait in cycles, must be below 2**21
//
// Ports
//   CLK            clock, rising edge
//   RST_N          asynchronous active-low reset
//   write_valid    client has a byte to send
//   write_rs       0 = instruction, 1 = data
//   write_data     byte to send
//   write_ready    controller accepts a byte this cycle
//   init_done      init sequence complete, held until reset
//   sendCommand    one-cycle start pulse to the transfer unit
//   command        {RS, nibble} for the transfer unit
//   commandDelay   post-nibble delay in cycles
//   commandDone    one-cycle completion pulse from the transfer unit
// ---------------------------------------------------------------------------
module lcd_controller #(
  parameter int unsigned FREQ           = 50000000,
  parameter int unsigned POWERUP_CYCLES = FREQ / 1000 * 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        write_valid,
  input  logic        write_rs,
  input  logic [7:0]  write_data,
  output logic        write_ready,
  output logic        init_done,
  output logic        sendCommand,
  output logic [4:0]  command,
  output logic [20:0] commandDelay,
  input  logic        commandDone
);

  // -------------------------------------------------------------------------
  // Timing constants, all resolved at elaboration. Delays are expressed in
  // microseconds of the HD44780 datasheet and scaled by the clock rate.
  // -------------------------------------------------------------------------
  localparam int unsigned T_US = FREQ / 1000000;

  localparam logic [20:0] DLY_1US    = 21'(T_US * 1);
  localparam logic [20:0] DLY_40US   = 21'(T_US * 40);
  localparam logic [20:0] DLY_100US  = 21'(T_US * 100);
  localparam logic [20:0] DLY_1640US = 21'(T_US * 1640);
  localparam logic [20:0] DLY_4100US = 21'(T_US * 4100);

  localparam logic [20:0] PWR_LAST   = 21'(POWERUP_CYCLES - 1);

  localparam logic [3:0]  INIT_LAST  = 4'd11;

  // -------------------------------------------------------------------------
  // Sequencer states
  // -------------------------------------------------------------------------
  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT     = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_IDLE     = 3'd4;

  // What the transfer currently in flight belongs to; decides where GAP goes.
  localparam logic [1:0] PH_INIT = 2'd0;
  localparam logic [1:0] PH_HI   = 2'd1;
  localparam logic [1:0] PH_LO   = 2'd2;

  // -------------------------------------------------------------------------
  // Init ROM: {nibble, delay}. Three "function set 8-bit" wake-up nibbles,
  // the switch to 4-bit mode, then function set 0x28, display on 0x0C,
  // clear 0x01 and entry mode 0x06, each sent as high/low nibble pairs.
  // -------------------------------------------------------------------------
  function automatic logic [24:0] init_rom(input logic [3:0] idx);
    logic [24:0] entry;
    case (idx)
      4'd0:    entry = {4'h3, DLY_4100US};
      4'd1:    entry = {4'h3, DLY_100US};
      4'd2:    entry = {4'h3, DLY_40US};
      4'd3:    entry = {4'h2, DLY_40US};
      4'd4:    entry = {4'h2, DLY_1US};
      4'd5:    entry = {4'h8, DLY_40US};
      4'd6:    entry = {4'h0, DLY_1US};
      4'd7:    entry = {4'hC, DLY_40US};
      4'd8:    entry = {4'h0, DLY_1US};
      4'd9:    entry = {4'h1, DLY_1640US};
      4'd10:   entry = {4'h0, DLY_1US};
      4'd11:   entry = {4'h6, DLY_40US};
      default: entry = {4'h0, DLY_40US};
    endcase
    return entry;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]  state;
  logic [1:0]  phase;
  logic [20:0] pwr_cnt;
  logic [3:0]  init_idx;
  logic        lat_rs;    // RS of the byte being sent
  logic [3:0]  lat_lo;    // low nibble of the byte being sent
  logic        lat_slow;  // low nibble needs the long clear/home delay

  // ROM lookup for the next init transfer: entry 0 when leaving power-up,
  // otherwise the entry after the one just completed.
  logic [3:0]  rom_idx;
  logic [3:0]  rom_nib;
  logic [20:0] rom_dly;

  // Clear (0x01) and return-home (0x02/0x03) instructions need 1.64 ms.
  logic        wr_slow;

  // NOTE: every always_comb output gets a value before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rom_idx = 4'd0;
    if (state == ST_GAP) begin
      rom_idx = init_idx + 4'd1;
    end
    {rom_nib, rom_dly} = init_rom(rom_idx);
    wr_slow = !write_rs &&
              (write_data == 8'h01 || write_data == 8'h02 || write_data == 8'h03);
  end

  // -------------------------------------------------------------------------
  // Sequencer. command/commandDelay are loaded only on the edge that raises
  // sendCommand, so they stay stable for the whole transfer.
  // The init ROM is constant logic and needs no reset of its own.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge value of every other one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_PWR_WAIT;
      phase        <= PH_INIT;
      pwr_cnt      <= '0;
      init_idx     <= '0;
      lat_rs       <= 1'b0;
      lat_lo       <= '0;
      lat_slow     <= 1'b0;
      write_ready  <= 1'b0;
      init_done    <= 1'b0;
      sendCommand  <= 1'b0;
      command      <= '0;
      commandDelay <= '0;
    end else begin
      sendCommand <= 1'b0;

      case (state)
        ST_PWR_WAIT: begin
          if (pwr_cnt == PWR_LAST) begin
            state        <= ST_ISSUE;
            phase        <= PH_INIT;
            init_idx     <= 4'd0;
            sendCommand  <= 1'b1;
            command      <= {1'b0, rom_nib};
            commandDelay <= rom_dly;
          end else begin
            pwr_cnt <= pwr_cnt + 21'd1;
          end
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
        end

        // commandDone is only meaningful here; elsewhere it may be a stray
        // pulse from a transfer that was in flight when reset hit.
        ST_WAIT: begin
          if (commandDone) begin
            state <= ST_GAP;
          end
        end

        // One idle cycle: the transfer unit sits in its done state now and
        // would drop a start pulse issued in it.
        ST_GAP: begin
          case (phase)
            PH_INIT: begin
              if (init_idx == INIT_LAST) begin
                state       <= ST_IDLE;
                write_ready <= 1'b1;
                init_done   <= 1'b1;
              end else begin
                state        <= ST_ISSUE;
                init_idx     <= init_idx + 4'd1;
                sendCommand  <= 1'b1;
                command      <= {1'b0, rom_nib};
                commandDelay <= rom_dly;
              end
            end
            PH_HI: begin
              state        <= ST_ISSUE;
              phase        <= PH_LO;
              sendCommand  <= 1'b1;
              command      <= {lat_rs, lat_lo};
              commandDelay <= lat_slow ? DLY_1640US : DLY_40US;
            end
            default: begin
              state       <= ST_IDLE;
              write_ready <= 1'b1;
            end
          endcase
        end

        // Accept goes straight to ISSUE with the high nibble so the start
        // pulse follows the accepting edge by one cycle.
        ST_IDLE: begin
          if (write_valid && write_ready) begin
            state        <= ST_ISSUE;
            phase        <= PH_HI;
            write_ready  <= 1'b0;
            lat_rs       <= write_rs;
            lat_lo       <= write_data[3:0];
            lat_slow     <= wr_slow;
            sendCommand  <= 1'b1;
            command      <= {write_rs, write_data[7:4]};
            commandDelay <= DLY_1US;
          end
        end

        default: begin
          state <= ST_PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// ---------------------------------------------------------------------------
// tb_lcd_controller
//
// Bench for lcd_controller. A behavioural transfer unit returns commandDone
// commandDelay+5 cycles after each start and then spends one cycle in a done
// state where a start is dropped. Expected transfers are pushed onto a
// scoreboard queue when the bench resets the DUT (init ROM) or hands it a
// byte (two nibbles), and popped when the DUT raises sendCommand.
// Cycle numbering: cyc counts rising edges after reset release; the model
// reads outputs 1 time unit after edge n-1 as the cycle-n values that the DUT
// presents to edge n.
// ---------------------------------------------------------------------------
module tb_lcd_controller;

  localparam int unsigned FREQ = 2000000;
  localparam int unsigned T_US = FREQ / 1000000;
  localparam int unsigned PWR  = 300;

  localparam logic [20:0] D1    = 21'(T_US * 1);
  localparam logic [20:0] D40   = 21'(T_US * 40);
  localparam logic [20:0] D100  = 21'(T_US * 100);
  localparam logic [20:0] D1640 = 21'(T_US * 1640);
  localparam logic [20:0] D4100 = 21'(T_US * 4100);

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  typedef struct packed {
    logic [4:0]  cmd;
    logic [20:0] dly;
  } xfer_t;

  typedef struct packed {
    logic        rs;
    logic [7:0]  data;
    logic [4:0]  hi;
    logic [4:0]  lo;
    logic [20:0] lo_dly;
    logic        hold;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        write_valid = 1'b0;
  logic        write_rs = 1'b0;
  logic [7:0]  write_data = 8'h00;
  logic        write_ready;
  logic        init_done;
  logic        sendCommand;
  logic [4:0]  command;
  logic [20:0] commandDelay;
  logic        commandDone = 1'b0;

  lcd_controller #(
    .FREQ           (FREQ),
    .POWERUP_CYCLES (PWR)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .write_valid  (write_valid),
    .write_rs     (write_rs),
    .write_data   (write_data),
    .write_ready  (write_ready),
    .init_done    (init_done),
    .sendCommand  (sendCommand),
    .command      (command),
    .commandDelay (commandDelay),
    .commandDone  (commandDone)
  );

  always #5 CLK = ~CLK;

  int    n_checks = 0;
  int    n_errors = 0;

  xfer_t exp_q[$];
  xfer_t init_exp[12];
  vec_t  tbl[10];
  vec_t  tbl_hold[3];

  // Shared between the transfer-unit model and the driver.
  int          cyc = 0;
  int          exp_sc_cyc = 0;
  int          last_done = -1000;
  int          done_at = 0;
  int          mode = M_IDLE;
  int          n_pulses = 0;
  bit          pwr_phase = 1'b1;
  bit          in_init = 1'b1;
  logic        prev_wr = 1'b0;
  logic [4:0]  cur_cmd = '0;
  logic [20:0] cur_dly = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural transfer unit + scoreboard consumer
  // -------------------------------------------------------------------------
  initial begin : xfer_model
    xfer_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      commandDone = 1'b0;
      case (mode)
        M_DONE: begin
          check("start_in_done_state", longint'(sendCommand), 0);
          mode = M_IDLE;
        end
        M_IDLE: begin
          if (sendCommand) begin
            check("issue_cycle", cyc, exp_sc_cyc);
            check("init_done_at_issue", longint'(init_done), in_init ? 0 : 1);
            check("pending_before_start", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("command", longint'(command), longint'(e.cmd));
              check("commandDelay", longint'(commandDelay), longint'(e.dly));
            end
            cur_cmd   = command;
            cur_dly   = commandDelay;
            done_at   = cyc + int'(commandDelay) + 5;
            mode      = M_BUSY;
            pwr_phase = 1'b0;
            n_pulses++;
          end
        end
        default: begin
          if (!pwr_phase &&
              (sendCommand || command != cur_cmd || commandDelay != cur_dly)) begin
            check("start_while_busy", longint'(sendCommand), 0);
            check("command_stable", longint'(command), longint'(cur_cmd));
            check("delay_stable", longint'(commandDelay), longint'(cur_dly));
          end
          if (cyc == done_at) begin
            commandDone = 1'b1;
            mode        = M_DONE;
            last_done   = cyc;
            if (!pwr_phase) exp_sc_cyc = cyc + 2;
          end
        end
      endcase
      if (write_ready && !prev_wr) begin
        check("ready_rise_cycle", cyc, last_done + 2);
        check("init_done_at_ready", longint'(init_done), 1);
        check("model_idle_at_ready", mode, M_IDLE);
        in_init = 1'b0;
      end
      prev_wr = write_ready;
    end
  end

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  task automatic apply_reset(input int hold_cycles);
    @(negedge CLK);
    RST_N     = 1'b0;
    pwr_phase = 1'b1;
    #1;
    check("rst_sendCommand", longint'(sendCommand), 0);
    check("rst_write_ready", longint'(write_ready), 0);
    check("rst_init_done", longint'(init_done), 0);
    check("rst_command", longint'(command), 0);
    check("rst_commandDelay", longint'(commandDelay), 0);
    repeat (hold_cycles) @(negedge CLK);
    exp_q.delete();
    foreach (init_exp[i]) exp_q.push_back(init_exp[i]);
    exp_sc_cyc = PWR;
    in_init    = 1'b1;
    last_done  = -1000;
    n_pulses   = 0;
    done_at    = done_at - cyc;
    cyc        = 0;
    RST_N      = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!write_ready && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, longint'(write_ready), 1);
  endtask

  task automatic send_byte(input vec_t v);
    @(negedge CLK);
    wait_ready("ready_timeout", 30000);
    write_valid = 1'b1;
    write_rs    = v.rs;
    write_data  = v.data;
    if (write_ready) begin
      check("init_done_at_accept", longint'(init_done), 1);
      exp_q.push_back({v.hi, D1});
      exp_q.push_back({v.lo, v.lo_dly});
      exp_sc_cyc = cyc + 1;
    end
    @(negedge CLK);
    if (!v.hold) write_valid = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin : driver
    int n;
    vec_t clr;

    init_exp[0]  = '{5'h03, D4100};
    init_exp[1]  = '{5'h03, D100};
    init_exp[2]  = '{5'h03, D40};
    init_exp[3]  = '{5'h02, D40};
    init_exp[4]  = '{5'h02, D1};
    init_exp[5]  = '{5'h08, D40};
    init_exp[6]  = '{5'h00, D1};
    init_exp[7]  = '{5'h0C, D40};
    init_exp[8]  = '{5'h00, D1};
    init_exp[9]  = '{5'h01, D1640};
    init_exp[10] = '{5'h00, D1};
    init_exp[11] = '{5'h06, D40};

    //            rs    data   hi     lo     lo_dly hold
    tbl[0] = '{1'b1, 8'h41, 5'h14, 5'h11, D40,   1'b0};
    tbl[1] = '{1'b0, 8'h01, 5'h00, 5'h01, D1640, 1'b0};
    tbl[2] = '{1'b0, 8'h80, 5'h08, 5'h00, D40,   1'b0};
    tbl[3] = '{1'b0, 8'h02, 5'h00, 5'h02, D1640, 1'b1};
    tbl[4] = '{1'b0, 8'h03, 5'h00, 5'h03, D1640, 1'b0};
    tbl[5] = '{1'b0, 8'h04, 5'h00, 5'h04, D40,   1'b0};
    tbl[6] = '{1'b1, 8'h01, 5'h10, 5'h11, D40,   1'b0};
    tbl[7] = '{1'b0, 8'h00, 5'h00, 5'h00, D40,   1'b0};
    tbl[8] = '{1'b0, 8'h10, 5'h01, 5'h00, D40,   1'b0};
    tbl[9] = '{1'b1, 8'hFF, 5'h1F, 5'h1F, D40,   1'b0};

    tbl_hold[0] = '{1'b1, 8'h55, 5'h15, 5'h15, D40, 1'b1};
    tbl_hold[1] = '{1'b1, 8'h56, 5'h15, 5'h16, D40, 1'b1};
    tbl_hold[2] = '{1'b0, 8'h57, 5'h05, 5'h07, D40, 1'b0};

    clr = '{1'b0, 8'h01, 5'h00, 5'h01, D1640, 1'b0};

    // Power-up and full init sequence.
    apply_reset(3);
    wait_ready("init_ready_timeout", 30000);
    check("init_pulse_count", n_pulses, 12);
    check("init_done_after_init", longint'(init_done), 1);

    // Byte writes from the vector table.
    foreach (tbl[i]) send_byte(tbl[i]);

    // Reset while the low nibble of a clear is in flight.
    send_byte(clr);
    n = 0;
    while (!(exp_q.size() == 0 && mode == M_BUSY && cur_cmd == 5'h01) && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check("clr_low_nibble_in_flight", longint'(cur_cmd), 5'h01);
    while (cyc < done_at - 60 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    // Client holds a byte valid through reset and the whole init.
    write_valid = 1'b1;
    write_rs    = 1'b1;
    write_data  = 8'h55;
    apply_reset(4);

    // Back-to-back bytes with write_valid never dropped between them.
    foreach (tbl_hold[i]) send_byte(tbl_hold[i]);

    n = 0;
    while (!(exp_q.size() == 0 && mode == M_IDLE && write_ready) && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("final_write_ready", longint'(write_ready), 1);
    check("rerun_pulse_count", n_pulses, 18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    repeat (90000) @(posedge CLK);
    n_errors++;
    n_checks++;
    $display("FAIL watchdog: simulation did not complete within 90000 cycles");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_controller.md
# lcd_controller

Sequencer for the 4-bit character-LCD transfer unit (the `sendCommand`/`commandDone` nibble engine). After reset it waits out LCD power-up, runs the fixed HD44780 4-bit initialisation sequence, then accepts byte writes (command or character) from the client over a valid/ready handshake. Each byte is split into two nibble transfers, each with the required post-nibble delay. It sits between application logic and the transfer unit and is the transfer unit's only driver.

## Interface
Parameters:
- `FREQ`, default 50000000: clock frequency in Hz. T_US = FREQ/1000000 (50 at default).
- `POWERUP_CYCLES`, default FREQ/1000*15 (750000): power-up wait in cycles. Must be below 2^21.

Ports:
- `CLK` in 1: clock; all state updates on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `write_valid` in 1: client has a byte to send.
- `write_rs` in 1: 0 = instruction, 1 = data (RS line).
- `write_data` in 8: byte to send.
- `write_ready` out 1: controller accepts a byte this cycle.
- `init_done` out 1: init sequence complete; stays high until reset.
- `sendCommand` out 1: one-cycle start pulse to the transfer unit.
- `command` out 5: {RS, nibble} to the transfer unit.
- `commandDelay` out 21: post-nibble delay in cycles, for the transfer unit.
- `commandDone` in 1: one-cycle completion pulse from the transfer unit.

## Operation
- All outputs are registered. In reset, every output is 0 and the state is PWR_WAIT.
- States:
  - PWR_WAIT: 21-bit counter runs from 0; at POWERUP_CYCLES-1 go to ISSUE with init index 0.
  - ISSUE: `sendCommand`=1 for one cycle; go to WAIT.
  - WAIT: hold `command`/`commandDelay`; on `commandDone` go to GAP.
  - GAP: one cycle. Next is ISSUE for the next init entry, IDLE after the last init entry, WR_LO after a user high nibble, or IDLE after a user low nibble.
  - IDLE: `write_ready`=1.
- The GAP cycle is mandatory: the transfer unit spends one cycle in its done state and drops a start pulse issued there.
- Init ROM, 12 nibble entries as (command, delay in cycles):
  - 03/205000, 03/5000, 03/2000, 02/2000
  - 02/50, 08/2000 (function set 0x28)
  - 00/50, 0C/2000 (display on 0x0C)
  - 00/50, 01/82000 (clear 0x01)
  - 00/50, 06/2000 (entry mode 0x06)
- `init_done` goes to 1 on entry to IDLE after init entry 11.
- User write: accepted when `write_valid` and `write_ready` are both high. The controller latches `write_rs`/`write_data`, drops `write_ready`, and goes to ISSUE.
  - High nibble: `command`={rs,data[7:4]}, `commandDelay`=T_US (50).
  - Low nibble: `command`={rs,data[3:0]}. `commandDelay`=82000 (1.64 ms) if rs=0 and data is 0x01, 0x02 or 0x03; otherwise 40*T_US (2000).
- `command`/`commandDelay` change only in the cycle `sendCommand` rises. They are stable from then until `commandDone`.
- `commandDone` outside WAIT is ignored. This covers a stray pulse from a transfer in flight at reset; the transfer unit has no reset.
- `write_ready` is 0 during PWR_WAIT, init, and any user transfer. Client inputs are ignored when `write_ready`=0. `write_valid` may be held high across those periods without side effects.
- Delay arithmetic is done on unsigned 21-bit values. All constants are computed at elaboration and must fit in 21 bits.

## Timing
- `RST_N` deasserted before edge 0: first `sendCommand` occurs at cycle POWERUP_CYCLES (750000).
- `commandDone` seen at cycle t: next `sendCommand` is at cycle t+2, or `write_ready`/`init_done` rise at cycle t+2.
- Accept at cycle a: high-nibble `sendCommand` at a+1.
- Second `commandDone` at cycle e: `write_ready`=1 at e+2. The earliest next accept is e+2.
- `sendCommand` is never high on two consecutive cycles. At most one transfer is outstanding.
- `RST_N` low at any time (including mid-WAIT): outputs clear asynchronously and the full power-up plus init sequence reruns. A `commandDone` arriving during PWR_WAIT has no effect.

## Test plan
Bench uses a behavioural transfer-unit model that returns `commandDone` after `commandDelay`+5 cycles, plus a one-cycle done state that drops starts.
1. Reset release: no `sendCommand` and `write_ready`=0 for cycles 0..749999. At 750000, `sendCommand`=1 with `command`=5'h03 and `commandDelay`=205000.
2. Full init: exactly 12 pulses matching the ROM (command/delay pairs in order). Each pulse is exactly 2 cycles after the prior `commandDone`. `init_done`=`write_ready`=1 two cycles after the 12th done.
3. Character write, rs=1, data=0x41: pulses {5'h14, 50} then {5'h11, 2000}. `write_ready`=0 in between; back to 1 at e+2.
4. Instruction clear, rs=0, data=0x01: pulses {5'h00, 50} then {5'h01, 82000}. Instruction rs=0, data=0x80 gives a low-nibble delay of 2000.
5. `write_valid` held high from reset with data 0x55: no accept before `init_done`. Back-to-back bytes are each accepted exactly once, and no start lands in the model's done state.
6. `RST_N` pulsed low during a user low-nibble WAIT: outputs are 0 immediately. The model's late `commandDone` is ignored, and the first `sendCommand` reappears 750000 cycles after release with 5'h03.
